// File: rtl/reg_file_sb.sv
// Register file with two combinational read ports, one write port and a
// pending-write scoreboard (one busy bit per register plus a live count).
module reg_file_sb #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int AW       = 5,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            stall,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            we,
    input  logic [AW-1:0]   wa,
    input  logic [XLEN-1:0] wd,
    input  logic            issue_en,
    input  logic [AW-1:0]   issue_rd,
    output logic            busy1,
    output logic            busy2,
    output logic [AW:0]     busy_cnt
);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;
    logic [AW:0]     cnt_nxt;
    logic            wr_acc;
    logic            set_acc;
    logic            cnt_inc;
    logic            cnt_dec;

    // Out-of-range addresses and a hardwired register 0 are neither
    // stored to, scoreboarded, nor readable (they read as zero).
    function automatic logic writable(input logic [AW-1:0] a);
        return (int'(a) < NREG) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    // Gating with reset_n keeps the bypass path quiet while in reset.
    assign wr_acc  = reset_n & we & ~stall & writable(wa);
    assign set_acc = issue_en & ~stall & writable(issue_rd);

    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned and infers a latch.
    always_comb begin
        rd1   = '0;
        rd2   = '0;
        busy1 = 1'b0;
        busy2 = 1'b0;
        if (writable(ra1)) begin
            if ((BYPASS != 0) && wr_acc && (wa == ra1)) begin
                rd1 = wd;
            end else begin
                rd1   = regs[ra1];
                busy1 = busy[ra1];
            end
        end
        if (writable(ra2)) begin
            if ((BYPASS != 0) && wr_acc && (wa == ra2)) begin
                rd2 = wd;
            end else begin
                rd2   = regs[ra2];
                busy2 = busy[ra2];
            end
        end
    end

    // Set is applied after clear so a same-register collision ends busy.
    always_comb begin
        busy_nxt = busy;
        if (wr_acc) begin
            busy_nxt[wa] = 1'b0;
        end
        if (set_acc) begin
            busy_nxt[issue_rd] = 1'b1;
        end
    end

    assign cnt_inc = set_acc && !busy[issue_rd];
    assign cnt_dec = wr_acc && busy[wa] && !(set_acc && (issue_rd == wa));
    assign cnt_nxt = busy_cnt + {{AW{1'b0}}, cnt_inc} - {{AW{1'b0}}, cnt_dec};

    // NOTE: the register array is cleared by reset because the contract
    // guarantees zero reads right after reset; this costs a reset net per
    // flop and rules out mapping the array onto a RAM macro.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            busy     <= '0;
            busy_cnt <= '0;
        end else if (!stall) begin
            if (wr_acc) begin
                regs[wa] <= wd;
            end
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed scenarios with literal
// expectations, then randomized traffic compared against a behavioural model.
module tb_reg_file_sb;

    localparam int XLEN = 32;
    localparam int NREG = 24;
    localparam int AW   = 5;

    logic            clock = 1'b0;
    logic            reset_n;
    logic            stall;
    logic [AW-1:0]   ra1, ra2, wa, issue_rd;
    logic [XLEN-1:0] rd1, rd2, wd;
    logic            we, issue_en, busy1, busy2;
    logic [AW:0]     busy_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    logic [XLEN-1:0] mreg [NREG];
    bit   [NREG-1:0] mbusy;

    reg_file_sb #(
        .XLEN(XLEN), .NREG(NREG), .AW(AW), .BYPASS(1), .ZERO_REG(1)
    ) dut (
        .clock(clock), .reset_n(reset_n), .stall(stall),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .we(we), .wa(wa), .wd(wd),
        .issue_en(issue_en), .issue_rd(issue_rd),
        .busy1(busy1), .busy2(busy2), .busy_cnt(busy_cnt)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [XLEN-1:0] act,
                         input logic [XLEN-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    endtask

    // Reference model: plain array of values, bit-set of pending registers.
    function automatic bit mwrt(input int a);
        return (a < NREG) && (a != 0);
    endfunction

    function automatic bit m_wacc();
        return reset_n && we && !stall && mwrt(int'(wa));
    endfunction

    function automatic logic [XLEN-1:0] m_rd(input int a);
        if (!reset_n || !mwrt(a)) return '0;
        if (m_wacc() && int'(wa) == a) return wd;
        return mreg[a];
    endfunction

    function automatic logic m_busy(input int a);
        if (!reset_n || !mwrt(a)) return 1'b0;
        if (m_wacc() && int'(wa) == a) return 1'b0;
        return mbusy[a];
    endfunction

    function automatic int m_cnt();
        int n = 0;
        for (int i = 0; i < NREG; i++) n += int'(mbusy[i]);
        return n;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) mreg[i] = '0;
            mbusy = '0;
        end else if (!stall) begin
            if (we && mwrt(int'(wa))) begin
                mreg[wa] = wd;
                mbusy[wa] = 1'b0;
            end
            if (issue_en && mwrt(int'(issue_rd))) mbusy[issue_rd] = 1'b1;
        end
    end

    always @(negedge clock) begin
        if (cmp_en) begin
            check("cmp_rd1", rd1, m_rd(int'(ra1)));
            check("cmp_rd2", rd2, m_rd(int'(ra2)));
            check("cmp_busy1", 32'(busy1), 32'(m_busy(int'(ra1))));
            check("cmp_busy2", 32'(busy2), 32'(m_busy(int'(ra2))));
            check("cmp_busy_cnt", 32'(busy_cnt), 32'(m_cnt()));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; stall = 1'b0; we = 1'b0; issue_en = 1'b0;
        wa = '0; wd = '0; issue_rd = '0; ra1 = 5'd1; ra2 = 5'd2;
        #2;
        check("reset_rd1", rd1, 32'h0);
        check("reset_busy_cnt", 32'(busy_cnt), 32'h0);
        #10 reset_n = 1'b1;
        cmp_en = 1'b1;
        tick();

        // Write with same-cycle bypass, then plain read back.
        ra1 = 5'd5; we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
        #1 check("bypass_rd1", rd1, 32'hDEADBEEF);
        tick();
        we = 1'b0;
        #1 check("readback_rd1", rd1, 32'hDEADBEEF);

        // Register 0 ignores writes and issues.
        we = 1'b1; wa = 5'd0; wd = 32'h12345678; ra1 = 5'd0;
        tick();
        we = 1'b0;
        #1 check("zero_rd1", rd1, 32'h0);
        issue_en = 1'b1; issue_rd = 5'd0;
        tick();
        issue_en = 1'b0;
        #1 check("zero_issue_cnt", 32'(busy_cnt), 32'h0);

        // Scoreboard set/clear.
        issue_en = 1'b1; issue_rd = 5'd3;
        tick();
        issue_rd = 5'd7;
        tick();
        issue_en = 1'b0;
        #1 check("sb_cnt2", 32'(busy_cnt), 32'd2);
        ra1 = 5'd3;
        #1 check("sb_busy1", 32'(busy1), 32'd1);
        we = 1'b1; wa = 5'd3; wd = 32'h1;
        #1 check("sb_busy1_bypass", 32'(busy1), 32'd0);
        tick();
        we = 1'b0;
        #1 check("sb_cnt1", 32'(busy_cnt), 32'd1);

        // Same-register set and clear: set wins, count unchanged.
        issue_en = 1'b1; issue_rd = 5'd9;
        tick();
        issue_en = 1'b0;
        #1 check("col_pre_cnt", 32'(busy_cnt), 32'd2);
        issue_en = 1'b1; issue_rd = 5'd9; we = 1'b1; wa = 5'd9; wd = 32'h99;
        tick();
        issue_en = 1'b0; we = 1'b0; ra2 = 5'd9;
        #1 check("col_busy2", 32'(busy2), 32'd1);
        check("col_cnt", 32'(busy_cnt), 32'd2);
        check("col_rd2", rd2, 32'h99);

        // Stall freezes state and bypass; release applies both events.
        stall = 1'b1; we = 1'b1; wa = 5'd4; wd = 32'hA5;
        issue_en = 1'b1; issue_rd = 5'd6; ra1 = 5'd4;
        tick();
        #1 check("stall_rd1", rd1, 32'h0);
        check("stall_cnt", 32'(busy_cnt), 32'd2);
        stall = 1'b0;
        #1 check("unstall_bypass", rd1, 32'hA5);
        tick();
        we = 1'b0; issue_en = 1'b0;
        #1 check("unstall_rd1", rd1, 32'hA5);
        check("unstall_cnt", 32'(busy_cnt), 32'd3);

        // Asynchronous reset between edges.
        ra1 = 5'd6; ra2 = 5'd4;
        #1 check("pre_rst_busy1", 32'(busy1), 32'd1);
        reset_n = 1'b0;
        #1 check("arst_rd2", rd2, 32'h0);
        check("arst_busy1", 32'(busy1), 32'd0);
        check("arst_cnt", 32'(busy_cnt), 32'd0);
        reset_n = 1'b1;

        // Randomized traffic against the model.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            we       = ($urandom_range(0, 1) == 1);
            wa       = AW'($urandom_range(0, 31));
            wd       = $urandom;
            issue_en = ($urandom_range(0, 1) == 1);
            issue_rd = AW'($urandom_range(0, 31));
            stall    = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 3))
                0: ra1 = wa;
                1: ra1 = issue_rd;
                default: ra1 = AW'($urandom_range(0, 31));
            endcase
            ra2 = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, 31));
            if ($urandom_range(0, 299) == 0) begin
                #1 reset_n = 1'b0;
                #1 reset_n = 1'b1;
            end
        end
        tick();
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
